// File: rtl/nand_gate_core.sv
// Registered bitwise NAND stage with optional activity statistics.
// Statistics (toggle counter, all-low flag, input coverage) are built only when NAND_GATE_CORE_STATS_EN is defined.
module nand_gate_core #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             cov_clr,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             all_low,
  output logic [3:0]       cov
);

  localparam int unsigned COV_W = 4;

  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;

  // Bitwise NAND of the sampled operands
  always_comb begin
    out_d = ~(in_a & in_b);
  end

  // Result register; reset value matches all-zero operands
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= '1;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

`ifdef NAND_GATE_CORE_STATS_EN

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic             all_low_d;
  logic             all_low_q;
  logic [COV_W-1:0] cov_d;
  logic [COV_W-1:0] cov_q;
  logic             toggled_c;
  logic [1:0]       cov_idx_c;

  // Next-state for the statistics registers
  always_comb begin
    toggled_c = (out_d != out_q);
    cov_idx_c = {in_a[0], in_b[0]};
    cnt_d     = cnt_q;
    all_low_d = (out_d == '0);
    cov_d     = cov_q;
    if (toggled_c && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // Clear wins over recording this edge's combination
    if (cov_clr) begin
      cov_d = '0;
    end else begin
      cov_d = cov_q | (COV_W'(1) << cov_idx_c);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      all_low_q <= 1'b0;
      cov_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      all_low_q <= all_low_d;
      cov_q     <= cov_d;
    end
  end

  assign toggle_cnt = cnt_q;
  assign all_low    = all_low_q;
  assign cov        = cov_q;

`else

  logic unused_cov_clr;

  assign unused_cov_clr = cov_clr;
  assign toggle_cnt     = '0;
  assign all_low        = 1'b0;
  assign cov            = '0;

`endif

endmodule

// File: tb/tb_nand_gate_core.sv
// Scoreboard bench for nand_gate_core: directed test-plan scenarios plus random traffic
// checked against a behavioural model; honours NAND_GATE_CORE_STATS_EN.
module tb_nand_gate_core;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef NAND_GATE_CORE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [WIDTH-1:0] o;
    logic [CNT_W-1:0] cnt;
    logic             al;
    logic [3:0]       cv;
    int               step;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             cov_clr = 1'b0;
  logic [WIDTH-1:0] out;
  logic [CNT_W-1:0] toggle_cnt;
  logic             all_low;
  logic [3:0]       cov;

  nand_gate_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_a(in_a), .in_b(in_b), .cov_clr(cov_clr),
    .out(out), .toggle_cnt(toggle_cnt), .all_low(all_low), .cov(cov)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_step = 0;

  // Behavioural model state: value of out, toggle total, combinations seen
  logic [WIDTH-1:0] m_out;
  int               m_toggles;
  bit               m_seen[4];

  task automatic chk(input string nm, input int step, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", nm, step, act, req);
    end
  endtask

  // Drive one cycle of stimulus and push the model's view of the following edge
  task automatic step(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic clr, input logic rst);
    exp_t e;
    logic [WIDTH-1:0] nxt;
    logic [3:0] cvec;
    @(negedge clk);
    in_a = a; in_b = b; cov_clr = clr; rst_n = ~rst;
    if (rst) begin
      m_out = '1;
      m_toggles = 0;
      foreach (m_seen[i]) m_seen[i] = 1'b0;
      e.al = 1'b0;
    end else begin
      nxt = ~(a & b);
      if (nxt != m_out && m_toggles < CNT_MAX) m_toggles++;
      if (clr) foreach (m_seen[i]) m_seen[i] = 1'b0;
      else m_seen[2 * int'(a[0]) + int'(b[0])] = 1'b1;
      e.al = (nxt == '0);
      m_out = nxt;
    end
    cvec = '0;
    foreach (m_seen[i]) cvec[i] = m_seen[i];
    e.o    = m_out;
    e.cnt  = STATS ? CNT_W'(m_toggles) : '0;
    e.al   = STATS ? e.al : 1'b0;
    e.cv   = STATS ? cvec : 4'b0000;
    e.step = n_step;
    n_step++;
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int n);
    for (int i = 0; i < n; i++) step(a, b, 1'b0, 1'b0);
  endtask

  // Monitor: every edge presents a result; compare against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out", e.step, 32'(out), 32'(e.o));
        chk("toggle_cnt", e.step, 32'(toggle_cnt), 32'(e.cnt));
        chk("all_low", e.step, 32'(all_low), 32'(e.al));
        chk("cov", e.step, 32'(cov), 32'(e.cv));
      end
    end
  end

  initial begin
    int wait_cyc;
    logic [WIDTH-1:0] ra, rb;
    // Truth table on full-width vectors
    step('1, '1, 1'b0, 1'b1);
    hold('0, '0, 10);
    hold('1, '0, 10);
    hold('0, '1, 10);
    hold('1, '1, 10);
    // Reset held two cycles with both operands high, then released
    step('1, '1, 1'b0, 1'b1);
    step('1, '1, 1'b0, 1'b1);
    hold('1, '1, 3);
    // Saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) step((i % 2 == 0) ? '0 : '1, (i % 2 == 0) ? '0 : '1, 1'b0, 1'b0);
    hold('1, '1, 2);
    // Coverage clear has priority over this edge's combination
    hold('0, '0, 1);
    hold('1, '0, 1);
    hold('0, '1, 1);
    step('0, '1, 1'b1, 1'b0);
    hold('0, '1, 1);
    // Wide vector
    step('1, '1, 1'b0, 1'b1);
    hold(8'hF0, 8'h3C, 2);
    hold(8'hFF, 8'hFF, 2);
    // Random traffic with occasional clear and reset
    for (int i = 0; i < 300; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if ($urandom_range(0, 3) == 0) rb = ra;
      if ($urandom_range(0, 5) == 0) begin ra = '1; rb = '1; end
      step(ra, rb, ($urandom_range(0, 15) == 0), ($urandom_range(0, 40) == 0));
    end
    // Drain the scoreboard with a bounded wait
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    chk("scoreboard_drained", n_step, 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
